// File: rtl/aud_stereo_fifo.sv
// rtl/aud_stereo_fifo.sv - stereo L/R pairing front end feeding a show-ahead frame FIFO
//
// Purpose: pairs left/right half-frames from an I2S-style receiver (WM8978
// bit clock domain) into stereo frames and buffers them in a circular FIFO.
//
// Ports:
//   aud_bclk  in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   aud_lrc   in   LR clock level sampled with rx_done (0 = left, 1 = right)
//   rx_done   in   one-cycle pulse per received half-frame
//   adc_data  in   received sample, low WL bits used
//   m_valid   out  head frame available
//   m_ready   in   consumer accepts head frame
//   m_left    out  head left sample (0 when empty)
//   m_right   out  head right sample (0 when empty)
//   level     out  frames stored, 0..DEPTH
//   ovf       out  sticky overflow flag
//   ovf_clr   in   clears ovf
//   sync_err  out  one-cycle pulse on an L/R pairing violation
module aud_stereo_fifo #(
  parameter int WL    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     aud_bclk,
  input  logic                     rst,
  input  logic                     aud_lrc,
  input  logic                     rx_done,
  input  logic [31:0]              adc_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WL-1:0]            m_left,
  output logic [WL-1:0]            m_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     sync_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {WAIT_L, WAIT_R} state_t;

  state_t          state, state_next;
  logic [WL-1:0]   pend_left, pend_next;
  logic [WL-1:0]   sample;
  logic            sync_err_next;
  logic            wr_req;
  logic            unused_hi;

  assign sample    = adc_data[WL-1:0];
  // Upper sample bits are intentionally ignored.
  assign unused_hi = ^(adc_data >> WL);

  // Pairing FSM: state register
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      state     <= WAIT_L;
      pend_left <= '0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_next;
      pend_left <= pend_next;
      sync_err  <= sync_err_next;
    end
  end

  // Pairing FSM: next state and write request
  always_comb begin
    state_next    = state;
    pend_next     = pend_left;
    sync_err_next = 1'b0;
    wr_req        = 1'b0;
    if (rx_done) begin
      case (state)
        WAIT_L: begin
          if (aud_lrc) begin
            sync_err_next = 1'b1;          // orphan right, dropped
          end else begin
            pend_next  = sample;
            state_next = WAIT_R;
          end
        end
        WAIT_R: begin
          if (aud_lrc) begin
            wr_req     = 1'b1;
            state_next = WAIT_L;
          end else begin
            pend_next     = sample;        // previous right never came
            sync_err_next = 1'b1;
          end
        end
        default: state_next = WAIT_L;
      endcase
    end
  end

  // Frame storage: pointers carry one extra wrap bit to tell full from empty
  logic [2*WL-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [2*WL-1:0] head;
  logic            empty, full, pop, push, ovf_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign pop     = !empty && m_ready;
  // A pop frees the slot on the same edge, so a full FIFO can still take the write.
  assign push    = wr_req && (!full || pop);
  assign ovf_set = wr_req && full && !pop;

  always_ff @(posedge aud_bclk) begin
    if (push && !rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {pend_left, sample};
    end
  end

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A new overflow wins over a clear in the same cycle.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign head    = mem[rd_ptr[ADDR_W-1:0]];
  assign m_valid = !empty;
  assign m_left  = m_valid ? head[2*WL-1:WL] : '0;
  assign m_right = m_valid ? head[WL-1:0]    : '0;
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: doc/aud_stereo_fifo.md
AUD_STEREO_FIFO -- requirements
Module: aud_stereo_fifo

Interface
REQ-001 SHALL have parameter WL, default 16: audio word length in bits, range 8..32.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO depth in stereo frames, a power of 2, minimum 2; ADDR_W = log2(DEPTH).
REQ-003 SHALL have port aud_bclk, input, 1: the single clock (WM8978 bit clock); all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port aud_lrc, input, 1: WM8978 LR clock level; 0 = left, 1 = right.
REQ-006 SHALL have port rx_done, input, 1: one-cycle pulse from the upstream receiver, one per channel half-frame.
REQ-007 SHALL have port adc_data, input, 32: received sample; valid when rx_done = 1; sample in bits [WL-1:0], two's complement.
REQ-008 SHALL have port m_valid, output, 1: a stereo frame is available at the head.
REQ-009 SHALL have port m_ready, input, 1: consumer accepts the head frame.
REQ-010 SHALL have port m_left, output, WL: left sample of the head frame.
REQ-011 SHALL have port m_right, output, WL: right sample of the head frame.
REQ-012 SHALL have port level, output, ADDR_W+1: number of frames stored, 0..DEPTH.
REQ-013 SHALL have port ovf, output, 1: sticky overflow flag.
REQ-014 SHALL have port ovf_clr, input, 1: clears ovf.
REQ-015 SHALL have port sync_err, output, 1: one-cycle pulse on an L/R pairing violation.

Function
REQ-016 SHALL sample aud_lrc together with adc_data on each rx_done cycle to tag the channel.
REQ-017 SHALL implement a pairing FSM with states WAIT_L and WAIT_R; WAIT_L after reset.
REQ-018 WAIT_L, rx_done with aud_lrc = 0 -> latch adc_data[WL-1:0] as pending left; go to WAIT_R.
REQ-019 WAIT_L, rx_done with aud_lrc = 1 -> discard the sample (orphan right); pulse sync_err for one cycle; stay in WAIT_L.
REQ-020 WAIT_R, rx_done with aud_lrc = 1 -> issue a write of frame {pending left, adc_data[WL-1:0]}; go to WAIT_L.
REQ-021 WAIT_R, rx_done with aud_lrc = 0 -> overwrite the pending left (previous right lost); pulse sync_err; stay in WAIT_R.
REQ-022 No rx_done -> FSM holds its state and the pending left.
REQ-023 Storage SHALL be a circular buffer of DEPTH frames with ADDR_W+1-bit read and write pointers; pointers wrap modulo 2*DEPTH; empty = pointers equal; full = low bits equal and MSBs differ.
REQ-024 Read port SHALL be show-ahead: m_valid = not empty; m_left/m_right show the head frame combinationally; both SHALL be 0 while m_valid = 0.
REQ-025 Pop SHALL occur on an edge where m_valid = 1 and m_ready = 1; m_ready while empty is ignored.
REQ-026 A write SHALL be accepted if level < DEPTH, or if a pop occurs in the same cycle.
REQ-027 A write issued when full with no pop SHALL be dropped and SHALL set ovf; existing contents stay unchanged.
REQ-028 Latency: a frame written on edge t SHALL give m_valid = 1 after edge t if the FIFO was empty (one cycle from the right-channel rx_done).
REQ-029 level SHALL update on the same edge as the pointers: +1 for write only, -1 for pop only, unchanged for simultaneous write and pop.
REQ-030 ovf SHALL stay set until ovf_clr = 1; if ovf_clr and a new overflow occur in the same cycle, ovf SHALL remain 1.
REQ-031 Frame order SHALL be strictly FIFO; left and right of one frame SHALL never be split across entries.

Reset
REQ-032 With rst = 1 at an edge: FSM -> WAIT_L, pending left -> 0, pointers -> 0, level -> 0, m_valid -> 0, m_left/m_right -> 0, ovf -> 0, sync_err -> 0.
REQ-033 Reset mid-operation SHALL discard all stored frames and any pending left; rx_done during rst SHALL be ignored.
REQ-034 Storage RAM contents need not be reset.

Verification
REQ-035 Pairing: rx_done L = 0x1234, then R = 0xABCD, m_ready = 1 -> m_valid for exactly one cycle, m_left = 0x1234, m_right = 0xABCD, level returns to 0.
REQ-036 Fill and overflow: m_ready = 0, 9 L/R pairs with DEPTH = 8 -> level = 8, ovf = 1, and popping returns pairs 1..8 in order; pair 9 is absent.
REQ-037 Simultaneous operations: FIFO full, pop on the same cycle as a right rx_done -> write accepted, level stays 8, ovf stays 0.
REQ-038 Sync errors: R sample while in WAIT_L -> sync_err pulse and no write; L = 0x0001, L = 0x0002, R = 0x0003 -> one sync_err pulse and frame {0x0002, 0x0003}.
REQ-039 Reset mid-frame: rst pulsed after an L with 3 frames stored -> level = 0, m_valid = 0; the following R alone -> sync_err and no write.
REQ-040 ovf_clr: after overflow, ovf_clr = 1 for one cycle with no new overflow -> ovf = 0 and FIFO contents unchanged.
